// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the unified memory port arbiter.
package arb_pkg;

  // Arbiter FSM states: waiting for a request, or one access in flight.
  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Which requester owns the access that is currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  // Largest legal memory latency and starvation limit.
  localparam int unsigned ARB_MEM_LAT_MAX    = 15;
  localparam int unsigned ARB_STARVE_MAX_MAX = 255;

  // Counter widths wide enough for the largest legal settings.
  localparam int unsigned ARB_LAT_CNT_W_MAX    = $clog2(ARB_MEM_LAT_MAX + 1);
  localparam int unsigned ARB_STARVE_CNT_W_MAX = $clog2(ARB_STARVE_MAX_MAX + 1);

  // Width of the latency counter that must hold the values 0..mem_lat.
  function automatic int unsigned lat_cnt_width(input int unsigned mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

  // Width of the starvation counter that must hold the values 0..starve_max.
  function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Loadable up-counter that runs from 1 up to MAX_CNT and then holds,
// raising done while it sits at MAX_CNT. A count of 0 means idle.
module mem_arb_lat_timer #(
  parameter int unsigned MAX_CNT = 2,
  parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: load restarts at 1, clear returns to idle, otherwise advance until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_ONE;
    end else if (clear) begin
      cnt_d = '0;
    end else if ((cnt_q != '0) && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register with synchronous reset to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the load/store path. One access in flight at a time; data wins unless
// fetch has been passed over STARVE_MAX times in a row.
// Optional feature: define ARB_PERF_CNT_EN to build the stall counters;
// otherwise if_stall_cnt and d_stall_cnt are tied to zero.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic [31:0]   if_stall_cnt,
  output logic [31:0]   d_stall_cnt
);

  localparam int unsigned LAT_W = lat_cnt_width(MEM_LAT);
  localparam int unsigned SW    = starve_cnt_width(STARVE_MAX);

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic       we_q, we_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [LAT_W-1:0] lat_cnt;
  logic             lat_done;

  logic idle_sel;
  logic fetch_forced;
  logic d_win;
  logic if_win;
  logic grant;
  logic in_flight;
  logic resp_cycle;

  // Grant selection: only in IDLE and never while reset is asserted; data wins unless fetch is starved.
  always_comb begin
    idle_sel     = (state_q == ARB_IDLE) && !rst;
    fetch_forced = if_req && (starve_q == STARVE_LIM);
    d_win        = idle_sel && d_req && !fetch_forced;
    if_win       = idle_sel && if_req && !d_win;
    grant        = d_win || if_win;
    in_flight    = (state_q == ARB_BUSY) && !rst;
    resp_cycle   = in_flight && lat_done;
  end

  mem_arb_lat_timer #(
    .MAX_CNT (MEM_LAT),
    .CNT_W   (LAT_W)
  ) u_lat_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (grant),
    .clear (resp_cycle),
    .cnt   (lat_cnt),
    .done  (lat_done)
  );

  // Next-state logic for the FSM, the owner/write flags and the starvation counter.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d = ARB_BUSY;
          if (d_win) begin
            owner_d = OWN_D;
            we_d    = d_we;
            if (if_req && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + STARVE_ONE;
            end
          end else begin
            owner_d  = OWN_IF;
            we_d     = 1'b0;
            starve_d = '0;
          end
        end
      end
      ARB_BUSY: begin
        if (lat_done) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
          we_d    = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        we_d    = 1'b0;
      end
    endcase
  end

  // FSM and arbitration state registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  // Memory command and requester responses; only the owner ever sees rvalid or data.
  always_comb begin
    if_gnt    = if_win;
    d_gnt     = d_win;
    mem_req   = grant;
    mem_we    = d_win && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'h0;
    if (d_win) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_win) begin
      mem_addr  = if_addr;
      mem_be    = 4'hF;
    end
    busy      = in_flight;
    if_rvalid = resp_cycle && (owner_q == OWN_IF);
    d_rvalid  = resp_cycle && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = (d_rvalid && !we_q) ? mem_rdata : 32'h0;
  end

  // A busy arbiter always has a running latency count.
  a_busy_counting : assert property (@(posedge clk) disable iff (rst)
    (state_q == ARB_BUSY) |-> (lat_cnt != '0));

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d;
  logic [31:0] d_stall_q, d_stall_d;

  // Saturating stall counters: cycles where a request is waiting without a grant.
  always_comb begin
    if_stall_d = if_stall_q;
    d_stall_d  = d_stall_q;
    if (if_req && !if_win && (if_stall_q != 32'hFFFF_FFFF)) begin
      if_stall_d = if_stall_q + 32'd1;
    end
    if (d_req && !d_win && (d_stall_q != 32'hFFFF_FFFF)) begin
      d_stall_d = d_stall_q + 32'd1;
    end
  end

  // Stall counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_q <= 32'h0;
      d_stall_q  <= 32'h0;
    end else begin
      if_stall_q <= if_stall_d;
      d_stall_q  <= d_stall_d;
    end
  end

  assign if_stall_cnt = rst ? 32'h0 : if_stall_q;
  assign d_stall_cnt  = rst ? 32'h0 : d_stall_q;
`else
  assign if_stall_cnt = 32'h0;
  assign d_stall_cnt  = 32'h0;
`endif

endmodule
